ysyx_22041412_clint: RTL and testbench
======================================

YSYX_22041412_CLINT -- requirements
Module: ysyx_22041412_clint

Interface
REQ-001 Parameter NHART, default 2, meaning number of harts served (1..8).
REQ-002 Parameter PRESCALE, default 1, meaning clk cycles per mtime tick (1..256).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tick_en  input  1  global timer enable; 0 freezes the prescaler and mtime.
REQ-006 req_valid  input  1  register-access request valid.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  16  byte offset within the CLINT window.
REQ-010 req_wdata  input  64  write data.
REQ-011 rsp_valid  output  1  response valid.
REQ-012 rsp_ready  input  1  requester accepts the response.
REQ-013 rsp_rdata  output  64  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  access to an unmapped or misaligned address.
REQ-015 mtip  output  NHART  per-hart timer interrupt pending.
REQ-016 msip  output  NHART  per-hart software interrupt pending.

Function
REQ-017 The address map SHALL be: MSIP[h] at 0x0000+4h (bit 0 only), MTIMECMP[h] at 0x4000+8h (64-bit), MTIME at 0xBFF8 (64-bit).
REQ-018 Access SHALL be 64-bit for MTIMECMP/MTIME (addr[2:0]==0) and 32-bit for MSIP (addr[1:0]==0); anything else, or h>=NHART, SHALL set rsp_err=1 and have no side effect.
REQ-019 Handshake FSM states: IDLE (req_ready=1, rsp_valid=0) and RESP (req_ready=0, rsp_valid=1).
REQ-020 IDLE->RESP on req_valid; the write takes effect and the read data is captured on that edge, so response latency is 1 cycle.
REQ-021 RESP->IDLE on rsp_ready; rsp_rdata/rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-022 Only one request SHALL be outstanding; back-to-back requests SHALL sustain 1 per 2 cycles.
REQ-023 Prescaler: counts 0..PRESCALE-1 while tick_en=1; on its terminal count mtime increments by 1 and the prescaler wraps to 0; with PRESCALE=1, mtime increments every enabled cycle.
REQ-024 mtime SHALL wrap from 2^64-1 to 0 without any flag.
REQ-025 A software write to MTIME SHALL take priority over a same-cycle increment and SHALL clear the prescaler.
REQ-026 A read of MTIME SHALL return the value held before that edge's increment.
REQ-027 mtip[h] SHALL be registered: mtip[h] = (mtime >= mtimecmp[h]), unsigned, evaluated on the post-update values, so it is visible 1 cycle after the causing update.
REQ-028 Writing MTIMECMP[h] with a value greater than mtime SHALL clear mtip[h] on the following cycle.
REQ-029 msip[h] SHALL equal MSIP[h] bit 0; bits 31:1 read as 0 and ignore writes.
REQ-030 tick_en=0 SHALL NOT block register accesses.

Reset
REQ-031 On rst: mtime=0, prescaler=0, every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, MSIP=0, mtip=0, msip=0, FSM=IDLE, rsp_rdata=0, rsp_err=0.
REQ-032 rst asserted while in RESP SHALL drop the pending response; the next response is issued only for a new request.

Structure
REQ-033 Package ysyx_22041412_clint_pkg SHALL hold the address-offset constants (MSIP_BASE, MTIMECMP_BASE, MTIME_OFF) and the FSM state typedef.
REQ-034 The prescaler plus mtime counter SHALL be the sub-module ysyx_22041412_clint_timebase (outputs mtime; inputs tick_en, wr_en, wr_data).
REQ-035 The mtimecmp registers and comparators SHALL be generated per hart.

Verification
REQ-036 Reset, then read MTIMECMP[1] -> rsp_rdata=64'hFFFF_FFFF_FFFF_FFFF, rsp_err=0, mtip=0.
REQ-037 PRESCALE=4, tick_en=1 for 40 cycles after reset -> MTIME reads 10.
REQ-038 Write MTIMECMP[0]=20 and MTIME=15, PRESCALE=1 -> mtip[0] rises exactly 6 cycles after the MTIME write response; rewriting MTIMECMP[0]=100 clears it 1 cycle later.
REQ-039 Write MTIME=64'hFFFF_FFFF_FFFF_FFFE, tick_en=1 -> MTIME wraps to 0 after 2 ticks and mtip follows the new value.
REQ-040 Read at 0x0003, 0x4004, and 0x0008 with NHART=2 -> rsp_err=1, rsp_rdata=0, no register changes.
REQ-041 Write MSIP[1]=0xFFFF_FFFF with rsp_ready held low for 5 cycles -> msip=2'b10, rsp_valid stable, req_ready=0 until rsp_ready.

Source files
------------

// File: rtl/ysyx_22041412_clint_pkg.sv
// Shared constants and types for the CLINT block.
// Address offsets are byte offsets inside the 64 KiB CLINT window.
package ysyx_22041412_clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_OFF     = 16'hBFF8;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        T_NONE,
        T_MSIP,
        T_CMP,
        T_MTIME
    } target_t;

endpackage

// File: rtl/ysyx_22041412_clint_timebase.sv
// Prescaler plus free-running 64-bit mtime counter.
// A software write wins over a same-cycle tick and restarts the prescaler.
module ysyx_22041412_clint_timebase #(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_en,
    input  logic        wr_en,
    input  logic [63:0] wr_data,
    output logic [63:0] mtime
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
            presc <= '0;
        end else if (wr_en) begin
            mtime <= wr_data;
            presc <= '0;
        end else if (tick_en) begin
            if (presc == TERM) begin
                presc <= '0;
                mtime <= mtime + 64'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: rtl/ysyx_22041412_clint.sv
// Core-local interruptor: MSIP, per-hart MTIMECMP and a shared MTIME,
// behind a single-outstanding valid/ready request/response port.
module ysyx_22041412_clint
    import ysyx_22041412_clint_pkg::*;
#(
    parameter int NHART    = 2,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [15:0]      req_addr,
    input  logic [63:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [NHART-1:0] mtip,
    output logic [NHART-1:0] msip
);

    localparam logic [15:0] MSIP_SPAN = 16'(4 * NHART);
    localparam logic [15:0] CMP_SPAN  = 16'(8 * NHART);

    state_t      state;
    state_t      state_nxt;
    target_t     tgt;
    logic [2:0]  hart;
    logic [15:0] off_msip;
    logic [15:0] off_cmp;
    logic [63:0] rd_data;
    logic [63:0] mtime;
    logic [63:0] cmp [NHART];
    logic        acc;
    logic        wr;

    assign off_msip = req_addr - MSIP_BASE;
    assign off_cmp  = req_addr - MTIMECMP_BASE;

    // Out-of-window offsets wrap to large values and fail the span test.
    always_comb begin
        tgt  = T_NONE;
        hart = '0;
        unique case (1'b1)
            (req_addr == MTIME_OFF): begin
                tgt = T_MTIME;
            end
            (off_cmp < CMP_SPAN && off_cmp[2:0] == 3'd0): begin
                tgt  = T_CMP;
                hart = off_cmp[5:3];
            end
            (off_msip < MSIP_SPAN && off_msip[1:0] == 2'd0): begin
                tgt  = T_MSIP;
                hart = off_msip[4:2];
            end
            default: begin
                tgt = T_NONE;
            end
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (tgt)
            T_MSIP: begin
                for (int h = 0; h < NHART; h++)
                    if (hart == 3'(h)) rd_data = {63'd0, msip[h]};
            end
            T_CMP: begin
                for (int h = 0; h < NHART; h++)
                    if (hart == 3'(h)) rd_data = cmp[h];
            end
            T_MTIME: rd_data = mtime;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign acc = req_ready && req_valid;
    assign wr  = acc && req_we && (tgt != T_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (acc) begin
            rsp_rdata <= (req_we || tgt == T_NONE) ? 64'd0 : rd_data;
            rsp_err   <= (tgt == T_NONE);
        end
    end

    ysyx_22041412_clint_timebase #(
        .PRESCALE(PRESCALE)
    ) u_timebase (
        .clk    (clk),
        .rst    (rst),
        .tick_en(tick_en),
        .wr_en  (wr && tgt == T_MTIME),
        .wr_data(req_wdata),
        .mtime  (mtime)
    );

    for (genvar g = 0; g < NHART; g++) begin : g_hart
        logic        sel;
        logic [63:0] cmp_r;
        logic        mtip_r;
        logic        msip_r;

        assign sel = (hart == 3'(g));

        // Compare on registered values so mtip lags its cause by one cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                cmp_r  <= '1;
                mtip_r <= 1'b0;
                msip_r <= 1'b0;
            end else begin
                if (wr && tgt == T_CMP && sel) cmp_r <= req_wdata;
                if (wr && tgt == T_MSIP && sel) msip_r <= req_wdata[0];
                mtip_r <= (mtime >= cmp_r);
            end
        end

        assign cmp[g]  = cmp_r;
        assign mtip[g] = mtip_r;
        assign msip[g] = msip_r;
    end

endmodule

// File: tb/tb_ysyx_22041412_clint.sv
// Directed bench for the CLINT: register-map table plus timing sequences.
// A second instance with PRESCALE=4 exercises the prescaler.
module tb_ysyx_22041412_clint;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_en1, tick_en4;
    logic        req_valid, req_we, rsp_ready;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;

    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [63:0] rsp_rdata1;
    logic [1:0]  mtip1, msip1;
    logic        req_ready4, rsp_valid4, rsp_err4;
    logic [63:0] rsp_rdata4;
    logic [1:0]  mtip4, msip4;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    ysyx_22041412_clint #(.NHART(2), .PRESCALE(1)) u_dut (
        .clk(clk), .rst(rst), .tick_en(tick_en1),
        .req_valid(req_valid), .req_ready(req_ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .mtip(mtip1), .msip(msip1)
    );

    ysyx_22041412_clint #(.NHART(2), .PRESCALE(4)) u_dut4 (
        .clk(clk), .rst(rst), .tick_en(tick_en4),
        .req_valid(req_valid), .req_ready(req_ready4),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4),
        .mtip(mtip4), .msip(msip4)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        logic [1:0]  msip;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [15:0] a,
                         input logic [63:0] d);
        chk("req_ready_before", {63'd0, req_ready1}, 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        chk("rsp_valid_after", {63'd0, rsp_valid1}, 64'd1);
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic xfer(input logic we, input logic [15:0] a,
                        input logic [63:0] d, output logic [63:0] rd,
                        output logic er, output logic [63:0] rd4);
        issue(we, a, d);
        rd  = rsp_rdata1;
        er  = rsp_err1;
        rd4 = rsp_rdata4;
        complete();
    endtask

    initial begin
        logic [63:0] rd, rd4;
        logic        er;

        tbl[0]  = '{1'b0, 16'h4008, 64'h0, ONES, 1'b0, 2'b00};
        tbl[1]  = '{1'b0, 16'hBFF8, 64'h0, 64'h0, 1'b0, 2'b00};
        tbl[2]  = '{1'b1, 16'h4000, 64'h1234, 64'h0, 1'b0, 2'b00};
        tbl[3]  = '{1'b0, 16'h4000, 64'h0, 64'h1234, 1'b0, 2'b00};
        tbl[4]  = '{1'b0, 16'h0003, 64'h0, 64'h0, 1'b1, 2'b00};
        tbl[5]  = '{1'b0, 16'h4004, 64'h0, 64'h0, 1'b1, 2'b00};
        tbl[6]  = '{1'b0, 16'h0008, 64'h0, 64'h0, 1'b1, 2'b00};
        tbl[7]  = '{1'b1, 16'h0008, 64'h1, 64'h0, 1'b1, 2'b00};
        tbl[8]  = '{1'b1, 16'h4004, 64'h0, 64'h0, 1'b1, 2'b00};
        tbl[9]  = '{1'b0, 16'h4000, 64'h0, 64'h1234, 1'b0, 2'b00};
        tbl[10] = '{1'b1, 16'h0000, 64'hFFFF_FFFF, 64'h0, 1'b0, 2'b01};
        tbl[11] = '{1'b0, 16'h0000, 64'h0, 64'h1, 1'b0, 2'b01};
        tbl[12] = '{1'b0, 16'h0004, 64'h0, 64'h0, 1'b0, 2'b01};
        tbl[13] = '{1'b1, 16'h0000, 64'h0, 64'h0, 1'b0, 2'b00};
        tbl[14] = '{1'b0, 16'h0000, 64'h0, 64'h0, 1'b0, 2'b00};
        tbl[15] = '{1'b1, 16'hBFF8, 64'h55, 64'h0, 1'b0, 2'b00};
        tbl[16] = '{1'b0, 16'hBFF8, 64'h0, 64'h55, 1'b0, 2'b00};
        tbl[17] = '{1'b1, 16'h4010, 64'h7, 64'h0, 1'b1, 2'b00};
        tbl[18] = '{1'b0, 16'hBFFC, 64'h0, 64'h0, 1'b1, 2'b00};
        tbl[19] = '{1'b0, 16'h4008, 64'h0, ONES, 1'b0, 2'b00};

        rst       = 1'b1;
        tick_en1  = 1'b0;
        tick_en4  = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        tick_en4 = 1'b1;

        chk("rst_rsp_valid", {63'd0, rsp_valid1}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready1}, 64'd1);
        chk("rst_rsp_rdata", rsp_rdata1, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err1}, 64'd0);
        chk("rst_mtip", {62'd0, mtip1}, 64'd0);
        chk("rst_msip", {62'd0, msip1}, 64'd0);

        repeat (40) @(posedge clk);
        #1;
        tick_en4 = 1'b0;
        xfer(1'b0, 16'hBFF8, 64'h0, rd, er, rd4);
        chk("presc4_mtime", rd4, 64'd10);
        chk("frozen_mtime", rd, 64'd0);

        for (int i = 0; i < NV; i++) begin
            xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er, rd4);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, tbl[i].err});
            chk($sformatf("vec%0d_msip", i), {62'd0, msip1}, {62'd0, tbl[i].msip});
            chk($sformatf("vec%0d_mtip", i), {62'd0, mtip1}, 64'd0);
        end

        xfer(1'b1, 16'hBFF8, 64'd0, rd, er, rd4);
        xfer(1'b1, 16'h4000, 64'd20, rd, er, rd4);
        tick_en1 = 1'b1;
        issue(1'b1, 16'hBFF8, 64'd15);
        rsp_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            chk($sformatf("mtip_rise_c%0d", k), {63'd0, mtip1[0]},
                (k == 6) ? 64'd1 : 64'd0);
        end
        chk("mtip1_quiet", {63'd0, mtip1[1]}, 64'd0);
        issue(1'b1, 16'h4000, 64'd100);
        chk("mtip_hold_on_cmp_wr", {63'd0, mtip1[0]}, 64'd1);
        complete();
        chk("mtip_clear", {63'd0, mtip1[0]}, 64'd0);
        tick_en1 = 1'b0;

        tick_en1 = 1'b1;
        issue(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("wrap_mtip_fffe", {62'd0, mtip1}, 64'b01);
        @(posedge clk);
        #1;
        tick_en1 = 1'b0;
        chk("wrap_mtip_ffff", {62'd0, mtip1}, 64'b11);
        @(posedge clk);
        #1;
        chk("wrap_mtip_zero", {62'd0, mtip1}, 64'b00);
        xfer(1'b0, 16'hBFF8, 64'h0, rd, er, rd4);
        chk("wrap_mtime", rd, 64'd0);

        issue(1'b1, 16'h0004, 64'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_rsp_valid", {63'd0, rsp_valid1}, 64'd1);
            chk("hold_req_ready", {63'd0, req_ready1}, 64'd0);
            chk("hold_rsp_err", {63'd0, rsp_err1}, 64'd0);
            chk("hold_rsp_rdata", rsp_rdata1, 64'd0);
            chk("hold_msip", {62'd0, msip1}, 64'b10);
        end
        complete();
        chk("post_hold_rsp_valid", {63'd0, rsp_valid1}, 64'd0);
        chk("post_hold_req_ready", {63'd0, req_ready1}, 64'd1);
        xfer(1'b0, 16'h0004, 64'h0, rd, er, rd4);
        chk("msip1_read", rd, 64'd1);

        issue(1'b0, 16'h4008, 64'h0);
        chk("pre_rst_rdata", rsp_rdata1, ONES);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_drop_valid", {63'd0, rsp_valid1}, 64'd0);
        chk("rst_drop_rdata", rsp_rdata1, 64'd0);
        chk("rst_drop_msip", {62'd0, msip1}, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_no_resp", {63'd0, rsp_valid1}, 64'd0);
        xfer(1'b0, 16'h4000, 64'h0, rd, er, rd4);
        chk("rst_cmp0", rd, ONES);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
